// File: rtl/serial_link_ctrl.sv
// -----------------------------------------------------------------------------
// serial_link_ctrl
//
// Game Boy link-port controller. The CPU sees two registers:
//   FF01 (SB): 8-bit shift register, MSB goes out first and the incoming bit
//              enters at the LSB.
//   FF02 (SC): bit 7 = transfer start/busy, bit 0 = clock select
//              (1 = internal 8192 Hz clock, 0 = external clock from the partner).
//              Unused bits read as 1.
// A transfer moves 8 bits. It then raises int_serial_req, which stays high
// until the interrupt controller acknowledges it.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   a, din, dout      CPU address, write data, combinational read data
//   rd, wr            CPU read strobe (no side effects), one-cycle write strobe
//   sclk_out, sclk_oe shift clock to the pin and its output enable
//                     (sclk_oe = internal mode)
//   sclk_in, sin      asynchronous external shift clock and serial input
//   sout              serial data output
//   int_serial_req    serial interrupt request
//   int_serial_ack    serial interrupt acknowledge
//
// Handshake: int_serial_req is a level. The cycle on which both
// int_serial_req and int_serial_ack are high retires it, unless a new
// completion sets it on that same cycle. In that case it stays high.
// -----------------------------------------------------------------------------
module serial_link_ctrl #(
   parameter int CLK_DIV     = 512,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        rd,
   input  logic        wr,
   output logic        sclk_out,
   output logic        sclk_oe,
   input  logic        sclk_in,
   output logic        sout,
   input  logic        sin,
   output logic        int_serial_req,
   input  logic        int_serial_ack
);

   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = (HALF > 2) ? $clog2(HALF) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t          state;
   logic [7:0]      sb;
   logic            sc_start;
   logic            sc_clksel;
   logic [DW-1:0]   divider;
   logic [3:0]      bitcnt;

   // Reads have no side effects, so the read strobe is not needed.
   logic unused_rd;
   assign unused_rd = rd;

   // ---------------------------------------------------------------------------
   // Input synchronizers. They reset to 1, the idle level of both pins.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] sin_sync_q;
   logic                   sclk_sync;
   logic                   sin_sync;
   logic                   sclk_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '1;
         sin_sync_q  <= '1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], sin};
      end
   end

   assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
   assign sin_sync  = sin_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Decode and shift-edge generation
   // ---------------------------------------------------------------------------
   logic sel_sb, sel_sc, wr_sb, wr_sc, cpu_wr;
   logic half_tick, ext_fall, ext_rise;
   logic shift_fall, shift_rise, last_bit;

   assign sel_sb = (a == 16'hFF01);
   assign sel_sc = (a == 16'hFF02);
   assign wr_sb  = wr && sel_sb;
   assign wr_sc  = wr && sel_sc;
   assign cpu_wr = wr_sb || wr_sc;

   assign half_tick = (state == ACTIVE) && sc_clksel && (divider == DIV_LAST);
   assign ext_fall  = (state == ACTIVE) && !sc_clksel && sclk_prev && !sclk_sync;
   assign ext_rise  = (state == ACTIVE) && !sc_clksel && !sclk_prev && sclk_sync;

   // A register write in the same cycle takes priority and swallows the edge.
   assign shift_fall = !cpu_wr && ((half_tick && sclk_out) || ext_fall);
   assign shift_rise = !cpu_wr && ((half_tick && !sclk_out) || ext_rise);
   assign last_bit   = (bitcnt == 4'd1);

   assign sclk_oe = sc_clksel;

   // ---------------------------------------------------------------------------
   // Transfer FSM, registers and interrupt request
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         sb             <= 8'h00;
         sc_start       <= 1'b0;
         sc_clksel      <= 1'b0;
         divider        <= '0;
         bitcnt         <= 4'd0;
         sclk_out       <= 1'b1;
         sout           <= 1'b1;
         sclk_prev      <= 1'b1;
         int_serial_req <= 1'b0;
      end else begin
         sclk_prev <= sclk_sync;

         // The set further down comes later in this block, so it overrides
         // this clear when both happen on the same cycle.
         if (int_serial_req && int_serial_ack)
            int_serial_req <= 1'b0;

         // The divider runs only during an internally clocked transfer.
         if ((state == ACTIVE) && sc_clksel)
            divider <= (divider == DIV_LAST) ? '0 : divider + DW'(1);
         else
            divider <= '0;

         if (wr_sc) begin
            sc_clksel <= din[0];
            sc_start  <= din[7];
            if (din[7]) begin
               // Start a transfer, or restart one that is already running.
               state    <= ACTIVE;
               bitcnt   <= 4'd8;
               divider  <= '0;
               sclk_out <= 1'b1;
            end else if (state == ACTIVE) begin
               // Abort: sb keeps whatever has been shifted so far.
               state    <= IDLE;
               bitcnt   <= 4'd0;
               sclk_out <= 1'b1;
            end
         end else if (wr_sb) begin
            if (state == IDLE)
               sb <= din;
         end else if (shift_fall) begin
            if (half_tick)
               sclk_out <= 1'b0;
            sout <= sb[7];
         end else if (shift_rise) begin
            sclk_out <= 1'b1;
            sb       <= {sb[6:0], sin_sync};
            bitcnt   <= bitcnt - 4'd1;
            if (last_bit) begin
               sc_start       <= 1'b0;
               int_serial_req <= 1'b1;
               state          <= IDLE;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // CPU read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      dout = 8'hFF;
      if (sel_sb)
         dout = sb;
      else if (sel_sc)
         dout = {sc_start, 6'b111111, sc_clksel};
   end

endmodule

// File: tb/tb_serial_link_ctrl.sv
module tb_serial_link_ctrl;

   localparam int CLK_DIV = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [7:0]  din = 8'h00;
   wire  [7:0]  dout;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   wire         sclk_out;
   wire         sclk_oe;
   logic        sclk_in = 1'b1;
   wire         sout;
   logic        sin_drv = 1'b1;
   logic        loop_en = 1'b0;
   wire         sin;
   wire         int_serial_req;
   logic        int_serial_ack = 1'b0;

   assign sin = loop_en ? sout : sin_drv;

   serial_link_ctrl #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
      .sclk_out(sclk_out), .sclk_oe(sclk_oe), .sclk_in(sclk_in), .sout(sout),
      .sin(sin), .int_serial_req(int_serial_req), .int_serial_ack(int_serial_ack)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic mon_en = 1'b0;
   logic prev_sclk = 1'b1;
   int   fall_cnt = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every falling edge of the internal shift clock pops one expected sout bit.
   always @(negedge clk) begin
      if (mon_en && prev_sclk && !sclk_out) begin
         fall_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sout_unexpected got=%b exp=none", sout);
         end else begin
            check("sout_fall", {15'h0, sout}, {15'h0, exp_q.pop_front()});
         end
      end
      prev_sclk = sclk_out;
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      a = addr; din = data; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; a = 16'h0000;
   endtask

   task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      logic [7:0] val;
      a = addr; rd = 1'b1;
      #1 val = dout;
      rd = 1'b0; a = 16'h0000;
      check(tag, {8'h00, val}, {8'h00, exp});
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_irq(input int limit, output int k);
      k = 0;
      while (!int_serial_req && k < limit) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic ack_pulse();
      int_serial_ack = 1'b1;
      @(negedge clk);
      int_serial_ack = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
   endtask

   task automatic ext_pulse();
      @(negedge clk);
      sclk_in = 1'b0;
      wait_clk(8);
      check("ext_sout", {15'h0, sout}, {15'h0, exp_q.pop_front()});
      sclk_in = 1'b1;
      wait_clk(8);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      int k;
      int f0;

      // 1. Reset
      wait_clk(3);
      read_check("rst_sc", 16'hFF02, 8'h7E);
      read_check("rst_sb", 16'hFF01, 8'h00);
      read_check("rst_other", 16'h1234, 8'hFF);
      check("rst_sclk_out", {15'h0, sclk_out}, 16'h1);
      check("rst_sout", {15'h0, sout}, 16'h1);
      check("rst_irq", {15'h0, int_serial_req}, 16'h0);
      check("rst_oe", {15'h0, sclk_oe}, 16'h0);
      rst_n = 1'b1;
      wait_clk(4);
      read_check("post_rst_sc", 16'hFF02, 8'h7E);
      check("post_rst_sclk", {15'h0, sclk_out}, 16'h1);
      check("post_rst_irq", {15'h0, int_serial_req}, 16'h0);
      mon_en = 1'b1;

      // 2. Internal loopback
      loop_en = 1'b1;
      cpu_write(16'hFF01, 8'hA5);
      push_byte(8'hA5);
      f0 = fall_cnt;
      cpu_write(16'hFF02, 8'h81);
      check("oe_internal", {15'h0, sclk_oe}, 16'h1);
      wait_irq(200, k);
      check("loop_irq_latency", 16'(k), 16'(8 * CLK_DIV));
      wait_clk(10);
      check("loop_falls", 16'(fall_cnt - f0), 16'd8);
      check("loop_q_empty", 16'(exp_q.size()), 16'd0);
      read_check("loop_sb", 16'hFF01, 8'hA5);
      read_check("loop_sc", 16'hFF02, 8'h7F);
      ack_pulse();
      check("loop_ack_clear", {15'h0, int_serial_req}, 16'h0);
      loop_en = 1'b0;

      // 3. Constant 1 input, internal
      sin_drv = 1'b1;
      cpu_write(16'hFF01, 8'h00);
      push_byte(8'h00);
      f0 = fall_cnt;
      cpu_write(16'hFF02, 8'h81);
      wait_irq(200, k);
      check("ones_irq_latency", 16'(k), 16'(8 * CLK_DIV));
      wait_clk(4);
      read_check("ones_sb", 16'hFF01, 8'hFF);
      check("ones_falls", 16'(fall_cnt - f0), 16'd8);
      ack_pulse();

      // 5. Abort, then write SB after the abort
      sin_drv = 1'b0;
      cpu_write(16'hFF01, 8'h0F);
      push_byte(8'h00);
      void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
      void'(exp_q.pop_back()); void'(exp_q.pop_back());
      f0 = fall_cnt;
      cpu_write(16'hFF02, 8'h81);
      wait_clk(24);
      cpu_write(16'hFF01, 8'h55);
      cpu_write(16'hFF02, 8'h01);
      wait_clk(40);
      check("abort_irq", {15'h0, int_serial_req}, 16'h0);
      read_check("abort_sc", 16'hFF02, 8'h7F);
      check("abort_sclk", {15'h0, sclk_out}, 16'h1);
      read_check("abort_sb_partial", 16'hFF01, 8'h78);
      check("abort_falls", 16'(fall_cnt - f0), 16'd3);
      check("abort_q_empty", 16'(exp_q.size()), 16'd0);
      cpu_write(16'hFF01, 8'h55);
      read_check("abort_sb_write", 16'hFF01, 8'h55);

      // 4. External clock
      sin_drv = 1'b0;
      cpu_write(16'hFF01, 8'h3C);
      cpu_write(16'hFF02, 8'h80);
      check("ext_oe", {15'h0, sclk_oe}, 16'h0);
      push_byte(8'h3C);
      for (int p = 0; p < 7; p++) ext_pulse();
      wait_clk(6);
      check("ext_no_irq_7", {15'h0, int_serial_req}, 16'h0);
      @(negedge clk);
      sclk_in = 1'b0;
      wait_clk(8);
      check("ext_sout", {15'h0, sout}, {15'h0, exp_q.pop_front()});
      sclk_in = 1'b1;
      wait_clk(2);
      check("ext_irq_early", {15'h0, int_serial_req}, 16'h0);
      wait_clk(1);
      check("ext_irq_rise3", {15'h0, int_serial_req}, 16'h1);
      read_check("ext_sb", 16'hFF01, 8'h00);
      read_check("ext_sc", 16'hFF02, 8'h7E);
      check("ext_sclk_idle", {15'h0, sclk_out}, 16'h1);

      // 6. Interrupt race: completion on the same cycle as an ack of the old request
      check("race_pending", {15'h0, int_serial_req}, 16'h1);
      cpu_write(16'hFF01, 8'h00);
      push_byte(8'h00);
      f0 = fall_cnt;
      cpu_write(16'hFF02, 8'h81);
      wait_clk(8 * CLK_DIV - 1);
      int_serial_ack = 1'b1;
      @(negedge clk);
      int_serial_ack = 1'b0;
      check("race_irq_held", {15'h0, int_serial_req}, 16'h1);
      read_check("race_sc", 16'hFF02, 8'h7F);
      check("race_falls", 16'(fall_cnt - f0), 16'd8);
      ack_pulse();
      check("race_ack_clear", {15'h0, int_serial_req}, 16'h0);
      ack_pulse();
      check("ack_when_low", {15'h0, int_serial_req}, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
